// File: rtl/skew_pingpong_buf_pkg.sv
// Shared types and width helpers for the skewed ping-pong operand buffer.
package skew_pkg;

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    function automatic int beats(input int dim);
        return 2 * dim - 1;
    endfunction

    function automatic int row_w(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    function automatic int beat_w(input int dim);
        return (beats(dim) > 1) ? $clog2(beats(dim)) : 1;
    endfunction

endpackage

// File: rtl/skew_pingpong_buf_bank.sv
// One DIM x DIM operand bank: row write port plus a combinational skewed read
// that presents lane r with element k = t - r (zero outside the tile).
module skew_bank
    import skew_pkg::*;
#(
    parameter  int BITS = 8,
    parameter  int DIM  = 8,
    localparam int RW   = row_w(DIM),
    localparam int TW   = beat_w(DIM)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we_i,
    input  logic [RW-1:0]                  row_i,
    input  logic [DIM-1:0][BITS-1:0]       data_i,
    input  logic [TW-1:0]                  t_i,
    input  logic                           tr_i,
    output logic [DIM-1:0][BITS-1:0]       lanes_o
);

    logic [DIM-1:0][DIM-1:0][BITS-1:0] mem_q;
    logic [TW-1:0]                     k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[row_i] <= data_i;
        end
    end

    // Transpose swaps the row/column roles so the same bank feeds either array edge.
    always_comb begin
        lanes_o = '0;
        k       = '0;
        for (int r = 0; r < DIM; r++) begin
            if (t_i >= TW'(r) && (t_i - TW'(r)) < TW'(DIM)) begin
                k          = t_i - TW'(r);
                lanes_o[r] = tr_i ? mem_q[k[RW-1:0]][r] : mem_q[r][k[RW-1:0]];
            end
        end
    end

endmodule

// File: rtl/skew_pingpong_buf.sv
// Double-buffered skewed operand feeder: one bank loads rows while the other
// streams a diagonal wavefront of 2*DIM-1 beats into the systolic array edge.
module skew_pingpong_buf
    import skew_pkg::*;
#(
    parameter  int BITS = 8,
    parameter  int DIM  = 8,
    localparam int RW   = row_w(DIM)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_en,
    input  logic [RW-1:0]                       wr_row,
    input  logic signed [DIM-1:0][BITS-1:0]     wr_data,
    input  logic                                wr_commit,
    output logic                                wr_ready,
    input  logic                                start,
    input  logic                                transpose,
    input  logic                                en,
    output logic                                rd_ready,
    output logic                                busy,
    output logic                                out_valid,
    output logic signed [DIM-1:0][BITS-1:0]     out_data,
    output logic                                done
);

    localparam int            TW   = beat_w(DIM);
    localparam logic [TW-1:0] LAST = TW'(beats(DIM) - 1);

    state_t                           state_q;
    logic [1:0]                       full_q, full_d;
    logic                             wsel_q, wsel_d, rsel_q;
    logic [TW-1:0]                    t_q;
    logic                             tr_q;
    logic signed [DIM-1:0][BITS-1:0]  out_data_q;
    logic                             out_valid_q, done_q;
    logic [1:0][DIM-1:0][BITS-1:0]    lanes;
    logic                             wr_ok, commit_ok, last_beat;

    assign wr_ok     = wr_en && !full_q[wsel_q];
    assign commit_ok = wr_commit && !full_q[wsel_q];
    assign last_beat = (state_q == STREAM) && en && (t_q == LAST);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        skew_bank #(.BITS(BITS), .DIM(DIM)) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (wr_ok && (wsel_q == 1'(b))),
            .row_i   (wr_row),
            .data_i  (wr_data),
            .t_i     (t_q),
            .tr_i    (tr_q),
            .lanes_o (lanes[b])
        );
    end

    // Commit and stream end touch distinct banks, so both can apply in one cycle.
    always_comb begin
        full_d = full_q;
        wsel_d = wsel_q;
        if (commit_ok) begin
            full_d[wsel_q] = 1'b1;
            wsel_d         = !wsel_q;
        end
        if (last_beat) full_d[rsel_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            full_q      <= '0;
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            t_q         <= '0;
            tr_q        <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            full_q      <= full_d;
            wsel_q      <= wsel_d;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && full_q[rsel_q]) begin
                        state_q <= STREAM;
                        t_q     <= '0;
                        tr_q    <= transpose;
                    end
                end
                STREAM: begin
                    if (en) begin
                        out_data_q  <= lanes[rsel_q];
                        out_valid_q <= 1'b1;
                        if (last_beat) begin
                            done_q  <= 1'b1;
                            rsel_q  <= !rsel_q;
                            state_q <= IDLE;
                            t_q     <= '0;
                        end else begin
                            t_q <= t_q + TW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = (state_q == STREAM);
    assign rd_ready  = (state_q == IDLE) && full_q[rsel_q];
    assign wr_ready  = !full_q[wsel_q];

endmodule

// File: tb/tb_skew_pingpong_buf.sv
// Randomized scenario bench for skew_pingpong_buf against a tile-level reference model.
module tb_skew_pingpong_buf;

    localparam int BITS = 8;
    localparam int DIM  = 4;
    localparam int NB   = 2 * DIM - 1;
    localparam int RWB  = $clog2(DIM);

    typedef logic [DIM-1:0][BITS-1:0]          lanes_t;
    typedef logic [DIM-1:0][DIM-1:0][BITS-1:0] tile_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           wr_en = 1'b0, wr_commit = 1'b0, start = 1'b0, transpose = 1'b0, en = 1'b1;
    logic [RWB-1:0] wr_row = '0;
    lanes_t         wr_data = '0;
    logic           wr_ready, rd_ready, busy, out_valid, done;
    lanes_t         out_data;

    int n_chk = 0;
    int n_fail = 0;

    skew_pingpong_buf #(.BITS(BITS), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .wr_commit(wr_commit), .wr_ready(wr_ready), .start(start), .transpose(transpose),
        .en(en), .rd_ready(rd_ready), .busy(busy), .out_valid(out_valid),
        .out_data(out_data), .done(done)
    );

    always #5 clk = ~clk;

    // Lane r at beat t shows element (r, t-r) of the tile, or (t-r, r) when transposed.
    function automatic lanes_t exp_beat(input tile_t m, input int t, input bit tr);
        lanes_t v = '0;
        for (int r = 0; r < DIM; r++) begin
            int k;
            k = t - r;
            if (k >= 0 && k < DIM) v[r] = tr ? m[k][r] : m[r][k];
        end
        return v;
    endfunction

    function automatic tile_t gen_tile(input bit counting);
        tile_t m;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                m[r][c] = counting ? 8'(16 * r + c) : 8'($urandom);
        return m;
    endfunction

    // Reference model: two tiles, full flags, selectors and a beat index.
    tile_t  mem [2];
    bit [1:0] mfull;
    bit     mwsel, mrsel, mbusy, mtr;
    int     mt;
    lanes_t exp_data;
    bit     exp_valid, exp_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0; mem[1] <= '0;
            mfull <= '0; mwsel <= 0; mrsel <= 0; mbusy <= 0; mtr <= 0; mt <= 0;
            exp_data <= '0; exp_valid <= 0; exp_done <= 0;
        end else begin
            exp_valid <= 0;
            exp_done  <= 0;
            if (wr_en && !mfull[mwsel]) mem[mwsel][wr_row] <= wr_data;
            if (wr_commit && !mfull[mwsel]) begin
                mfull[mwsel] <= 1'b1;
                mwsel        <= !mwsel;
            end
            if (!mbusy) begin
                if (start && mfull[mrsel]) begin
                    mbusy <= 1; mt <= 0; mtr <= transpose;
                end
            end else if (en) begin
                exp_data  <= exp_beat(mem[mrsel], mt, mtr);
                exp_valid <= 1;
                if (mt == NB - 1) begin
                    exp_done     <= 1;
                    mfull[mrsel] <= 1'b0;
                    mrsel        <= !mrsel;
                    mbusy        <= 0;
                end else begin
                    mt <= mt + 1;
                end
            end
        end
    end

    wire [4+DIM*BITS:0] got_v = {out_valid, done, busy, rd_ready, wr_ready, out_data};
    wire [4+DIM*BITS:0] exp_v = {exp_valid, exp_done, mbusy, !mbusy && mfull[mrsel],
                                 !mfull[mwsel], exp_data};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wr_en = 0; wr_commit = 0; start = 0; transpose = 0; en = 1;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 0;
        cyc(); cyc();
        rst_n = 1;
        cyc();
    endtask

    task automatic load(input tile_t m);
        for (int r = 0; r < DIM; r++) begin
            wr_en = 1; wr_row = RWB'(r); wr_data = m[r]; wr_commit = (r == DIM - 1);
            cyc();
        end
        wr_en = 0; wr_commit = 0;
    endtask

    task automatic test_reset();
        idle_in();
        rst_n = 0;
        #1;
        cyc(); cyc();
        n_chk++; if (out_data !== '0)   begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_chk++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_chk++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_chk++; if (rd_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_ready got %b want 0", rd_ready); end
        n_chk++; if (wr_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        rst_n = 1;
        cyc();
        n_chk++; if (got_v !== exp_v) begin n_fail++; $display("FAIL reset_release got %h want %h", got_v, exp_v); end
    endtask

    task automatic run_known(input bit tr, input int la, input int lb, input int ea [NB], input int eb [NB], input string nm);
        do_reset();
        load(gen_tile(1));
        n_chk++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL %s_rd_ready got %b want 1", nm, rd_ready); end
        start = 1; transpose = tr; cyc(); start = 0; transpose = 0;
        n_chk++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_accept got busy=%b vld=%b want 1 0", nm, busy, out_valid); end
        for (int i = 0; i < NB; i++) begin
            cyc();
            n_chk++; if (got_v !== exp_v) begin n_fail++; $display("FAIL %s_model beat %0d got %h want %h", nm, i, got_v, exp_v); end
            n_chk++;
            if (out_data[la] !== 8'(ea[i]) || out_data[lb] !== 8'(eb[i]) || done !== (i == NB - 1) || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_lanes beat %0d got l%0d=%h l%0d=%h done=%b want %h %h %b", nm, i, la, out_data[la], lb, out_data[lb], done, 8'(ea[i]), 8'(eb[i]), (i == NB - 1));
            end
        end
        cyc();
        n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_end got busy=%b vld=%b want 0 0", nm, busy, out_valid); end
    endtask

    task automatic test_basic();
        int e0 [NB] = '{'h00, 'h01, 'h02, 'h03, 0, 0, 0};
        int e3 [NB] = '{0, 0, 0, 'h30, 'h31, 'h32, 'h33};
        run_known(1'b0, 0, 3, e0, e3, "basic");
    endtask

    task automatic test_transpose();
        int e0 [NB] = '{'h00, 'h10, 'h20, 'h30, 0, 0, 0};
        int e1 [NB] = '{0, 'h01, 'h11, 'h21, 'h31, 0, 0};
        run_known(1'b1, 0, 1, e0, e1, "transpose");
    endtask

    task automatic test_pingpong();
        tile_t ta, tb;
        ta = gen_tile(0);
        tb = gen_tile(0);
        tb[0][0] = ta[0][0] ^ 8'h55;
        do_reset();
        load(ta);
        start = 1; cyc(); start = 0;
        for (int i = 0; i < NB; i++) begin
            if (i < DIM) begin
                n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL pingpong_wr_ready row %0d got %b want 1", i, wr_ready); end
                wr_en = 1; wr_row = RWB'(i); wr_data = tb[i]; wr_commit = (i == DIM - 1);
            end else begin
                wr_en = 0; wr_commit = 0;
            end
            cyc();
            n_chk++; if (got_v !== exp_v) begin n_fail++; $display("FAIL pingpong_a beat %0d got %h want %h", i, got_v, exp_v); end
        end
        start = 1; cyc(); start = 0;
        for (int i = 0; i < NB; i++) begin
            cyc();
            n_chk++; if (got_v !== exp_v) begin n_fail++; $display("FAIL pingpong_b beat %0d got %h want %h", i, got_v, exp_v); end
            if (i == 0) begin
                n_chk++; if (out_data[0] !== tb[0][0]) begin n_fail++; $display("FAIL pingpong_b_first got %h want %h", out_data[0], tb[0][0]); end
            end
        end
    endtask

    task automatic test_both_full();
        tile_t ta, tb;
        lanes_t junk;
        ta = gen_tile(0); ta[0][0] = 8'h11;
        tb = gen_tile(0); tb[0][0] = 8'h22;
        junk = {DIM{8'h7F}};
        do_reset();
        load(ta);
        load(tb);
        n_chk++; if (wr_ready !== 1'b0 || rd_ready !== 1'b1) begin n_fail++; $display("FAIL full_flags got wr=%b rd=%b want 0 1", wr_ready, rd_ready); end
        wr_en = 1; wr_row = '0; wr_data = junk; cyc(); wr_en = 0;
        n_chk++; if (got_v !== exp_v) begin n_fail++; $display("FAIL full_drop got %h want %h", got_v, exp_v); end
        for (int s = 0; s < 2; s++) begin
            start = 1; cyc(); start = 0;
            for (int i = 0; i < NB; i++) begin
                cyc();
                n_chk++; if (got_v !== exp_v) begin n_fail++; $display("FAIL full_stream%0d beat %0d got %h want %h", s, i, got_v, exp_v); end
                if (i == 0) begin
                    n_chk++;
                    if (out_data[0] !== (s == 0 ? 8'h11 : 8'h22)) begin
                        n_fail++; $display("FAIL full_first%0d got %h want %h", s, out_data[0], (s == 0 ? 8'h11 : 8'h22));
                    end
                end
                if (i == 1) begin
                    n_chk++;
                    if (out_data[0] !== (s == 0 ? ta[0][1] : tb[0][1])) begin
                        n_fail++; $display("FAIL full_second%0d got %h want %h", s, out_data[0], (s == 0 ? ta[0][1] : tb[0][1]));
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        tile_t  t;
        lanes_t hold;
        int     nvalid;
        t = gen_tile(0);
        hold = exp_beat(t, 1, 1'b0);
        do_reset();
        load(t);
        start = 1; cyc(); start = 0;
        nvalid = 0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            nvalid += int'(out_valid);
            n_chk++; if (got_v !== exp_v) begin n_fail++; $display("FAIL stall_pre beat %0d got %h want %h", i, got_v, exp_v); end
        end
        en = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_chk++;
            if (out_valid !== 1'b0 || out_data !== hold || busy !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold cyc %0d got vld=%b data=%h want 0 %h", i, out_valid, out_data, hold);
            end
        end
        en = 1;
        for (int i = 0; i < NB - 2; i++) begin
            cyc();
            nvalid += int'(out_valid);
            n_chk++; if (got_v !== exp_v) begin n_fail++; $display("FAIL stall_post beat %0d got %h want %h", i, got_v, exp_v); end
        end
        n_chk++; if (nvalid != NB || done !== 1'b1) begin n_fail++; $display("FAIL stall_count got %0d done=%b want %0d 1", nvalid, done, NB); end
    endtask

    task automatic test_edges();
        do_reset();
        start = 1; cyc(); cyc(); start = 0;
        n_chk++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_start got busy=%b vld=%b want 0 0", busy, out_valid); end
        load(gen_tile(0));
        start = 1; cyc(); start = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_chk++; if (got_v !== exp_v) begin n_fail++; $display("FAIL abort_pre beat %0d got %h want %h", i, got_v, exp_v); end
        end
        rst_n = 0;
        #1;
        n_chk++;
        if (out_data !== '0 || out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || rd_ready !== 1'b0 || wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_outputs got %h want all zero with wr_ready 1", got_v);
        end
        cyc();
        rst_n = 1;
        cyc();
        n_chk++; if (rd_ready !== 1'b0 || got_v !== exp_v) begin n_fail++; $display("FAIL abort_after got %h want %h", got_v, exp_v); end
        start = 1; cyc(); start = 0;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_empty_start got busy=%b want 0", busy); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_transpose();
        test_pingpong();
        test_both_full();
        test_stall();
        test_edges();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
